// File: rtl/dn_mem_bridge.sv
// Boot-loader download bridge: turns loader strobes into single-byte SDRAM requests
// through a small command FIFO, checksums traffic and hands the CPU its start address.
//
// state  | meaning
// S_IDLE | waiting for a queued command, or for a pending execute once the queue drains
// S_REQ  | one memory request outstanding; ack timer running
// S_EXEC | single pc_load cycle; checksum comparison latched into verify_err
module dn_mem_bridge #(
  parameter int                FIFO_DEPTH  = 4,
  parameter int                ADDR_W      = 22,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                ACK_TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dn_go,
  input  logic              dn_wr,
  input  logic              dn_rd,
  input  logic [15:0]       dn_addr,
  input  logic [7:0]        dn_data,
  input  logic              execute_enable,
  input  logic [15:0]       execute_addr,
  input  logic              sdram_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              cpu_hold,
  output logic              pc_load,
  output logic [15:0]       pc_value,
  output logic [15:0]       wr_sum,
  output logic [15:0]       rd_sum,
  output logic              verify_err,
  output logic              fault,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_EXEC} state_t;

  state_t state, state_nxt;

  logic dn_go_q, dn_wr_q, dn_rd_q, exec_q;
  logic go_rise, wr_edge, rd_edge, exec_edge;

  logic              push_q, push_we;
  logic [ADDR_W-1:0] push_addr;
  logic [7:0]        push_data;

  logic              fifo_we   [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]        fifo_data [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full, fifo_push, overflow;

  logic             pop, req_done, req_timeout, enter_exec;
  logic             exec_pend;
  logic [TMR_W-1:0] tmr;

  assign go_rise   = dn_go & ~dn_go_q;
  assign wr_edge   = dn_go & dn_wr & ~dn_wr_q;
  assign rd_edge   = dn_go & dn_rd & ~dn_rd_q;
  assign exec_edge = execute_enable & ~exec_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dn_go_q <= 1'b0;
      dn_wr_q <= 1'b0;
      dn_rd_q <= 1'b0;
      exec_q  <= 1'b0;
    end else begin
      dn_go_q <= dn_go;
      dn_wr_q <= dn_wr;
      dn_rd_q <= dn_rd;
      exec_q  <= execute_enable;
    end
  end

  // A write edge wins over a read edge in the same cycle; the read is lost.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      push_q    <= 1'b0;
      push_we   <= 1'b0;
      push_addr <= '0;
      push_data <= '0;
    end else begin
      push_q <= wr_edge | rd_edge;
      if (wr_edge | rd_edge) begin
        push_we   <= wr_edge;
        push_addr <= BASE_ADDR + ADDR_W'(dn_addr);
        push_data <= dn_data;
      end
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fifo_push  = push_q & ~fifo_full;
  assign overflow   = push_q & fifo_full;

  always_ff @(posedge clk_sys) begin
    if (fifo_push) begin
      fifo_we[wr_ptr[PTR_W-1:0]]   <= push_we;
      fifo_addr[wr_ptr[PTR_W-1:0]] <= push_addr;
      fifo_data[wr_ptr[PTR_W-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)       rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Execute waits for the staging register too, so a just-seen strobe is never overtaken.
  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    req_done    = 1'b0;
    req_timeout = 1'b0;
    enter_exec  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty && sdram_ready) begin
          pop       = 1'b1;
          state_nxt = S_REQ;
        end else if (exec_pend && fifo_empty && !push_q) begin
          enter_exec = 1'b1;
          state_nxt  = S_EXEC;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          req_done  = 1'b1;
          state_nxt = S_IDLE;
        end else if (tmr == '0) begin
          req_timeout = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_EXEC:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mem_req = (state == S_REQ);
  assign pc_load = (state == S_EXEC);
  assign busy    = !fifo_empty || (state != S_IDLE);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tmr       <= '0;
    end else if (pop) begin
      mem_we    <= fifo_we[rd_ptr[PTR_W-1:0]];
      mem_addr  <= fifo_addr[rd_ptr[PTR_W-1:0]];
      mem_wdata <= fifo_data[rd_ptr[PTR_W-1:0]];
      tmr       <= TMR_LOAD;
    end else if (state == S_REQ && tmr != '0) begin
      tmr <= tmr - TMR_ONE;
    end
  end

  // Session start clears everything; a fault event in that same cycle still sticks.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_sum     <= '0;
      rd_sum     <= '0;
      verify_err <= 1'b0;
      fault      <= 1'b0;
    end else begin
      if (go_rise) begin
        wr_sum     <= '0;
        rd_sum     <= '0;
        verify_err <= 1'b0;
        fault      <= 1'b0;
      end else if (req_done) begin
        if (mem_we) wr_sum <= wr_sum + {8'h00, mem_wdata};
        else        rd_sum <= rd_sum + {8'h00, mem_rdata};
      end
      if (overflow || req_timeout || (wr_edge && rd_edge)) fault <= 1'b1;
      if (state == S_EXEC && wr_sum != rd_sum) verify_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      exec_pend <= 1'b0;
      pc_value  <= '0;
      cpu_hold  <= 1'b0;
    end else begin
      if (exec_edge) begin
        exec_pend <= 1'b1;
        pc_value  <= execute_addr;
      end else if (enter_exec) begin
        exec_pend <= 1'b0;
      end
      if (go_rise)                          cpu_hold <= 1'b1;
      else if (enter_exec)                  cpu_hold <= 1'b0;
      else if (!dn_go && !busy && !push_q)  cpu_hold <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dn_mem_bridge.sv
// Directed bench for dn_mem_bridge: a second instance with a high BASE_ADDR
// shares all inputs to exercise address wrap.
module tb_dn_mem_bridge;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        dn_go, dn_wr, dn_rd;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        execute_enable;
  logic [15:0] execute_addr;
  logic        sdram_ready;
  logic        mem_req, mem_we;
  logic [21:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        cpu_hold, pc_load;
  logic [15:0] pc_value, wr_sum, rd_sum;
  logic        verify_err, fault, busy;

  logic        w_mem_req, w_mem_we;
  logic [21:0] w_mem_addr;
  logic [7:0]  w_mem_wdata;
  logic        w_cpu_hold, w_pc_load;
  logic [15:0] w_pc_value, w_wr_sum, w_rd_sum;
  logic        w_verify_err, w_fault, w_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic        ack_en     = 1'b0;
  logic        corrupt_en = 1'b0;
  logic [7:0]  corrupt_addr = 8'h00;
  logic [7:0]  tb_mem [256];
  logic [21:0] addr_log [$];

  always #5 clk_sys = ~clk_sys;

  dn_mem_bridge dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dn_go(dn_go), .dn_wr(dn_wr), .dn_rd(dn_rd),
    .dn_addr(dn_addr), .dn_data(dn_data), .execute_enable(execute_enable),
    .execute_addr(execute_addr), .sdram_ready(sdram_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .pc_load(pc_load), .pc_value(pc_value),
    .wr_sum(wr_sum), .rd_sum(rd_sum), .verify_err(verify_err), .fault(fault), .busy(busy)
  );

  dn_mem_bridge #(.BASE_ADDR(22'h3FFFF0)) u_wrap (
    .clk_sys(clk_sys), .reset_n(reset_n), .dn_go(dn_go), .dn_wr(dn_wr), .dn_rd(dn_rd),
    .dn_addr(dn_addr), .dn_data(dn_data), .execute_enable(execute_enable),
    .execute_addr(execute_addr), .sdram_ready(sdram_ready), .mem_req(w_mem_req),
    .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .cpu_hold(w_cpu_hold), .pc_load(w_pc_load), .pc_value(w_pc_value),
    .wr_sum(w_wr_sum), .rd_sum(w_rd_sum), .verify_err(w_verify_err), .fault(w_fault), .busy(w_busy)
  );

  // Memory responder: acks one cycle after seeing mem_req, echoes stored bytes on reads.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk_sys); #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (ack_en && mem_req) begin
        mem_ack = 1'b1;
        addr_log.push_back(mem_addr);
        if (mem_we) begin
          tb_mem[mem_addr[7:0]] = mem_wdata;
          mem_rdata = 8'h00;
        end else begin
          mem_rdata = tb_mem[mem_addr[7:0]];
          if (corrupt_en && mem_addr[7:0] == corrupt_addr) mem_rdata = mem_rdata ^ 8'h01;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_sys); #1;
  endtask

  task automatic strobe_wr(input logic [15:0] a, input logic [7:0] d);
    dn_addr = a; dn_data = d; dn_wr = 1'b1;
    step();
    dn_wr = 1'b0;
    step();
  endtask

  task automatic strobe_rd(input logic [15:0] a);
    dn_addr = a; dn_rd = 1'b1;
    step();
    dn_rd = 1'b0;
    step();
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    step(); step();
    for (int i = 0; i < 200; i++) begin
      if (!busy && !mem_req && !mem_ack) begin
        done = 1'b1;
        break;
      end
      step();
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s idle_timeout: busy=%b mem_req=%b required idle within 200 cycles", name, busy, mem_req);
    end
  endtask

  task automatic start_session();
    dn_go = 1'b0;
    step();
    dn_go = 1'b1;
    step(); step();
  endtask

  task automatic do_execute(input logic [15:0] target, input logic exp_verr, input string name);
    int pulses = 0;
    logic prev_hold;
    execute_addr   = target;
    execute_enable = 1'b1;
    prev_hold      = cpu_hold;
    for (int i = 0; i < 12; i++) begin
      step();
      execute_enable = 1'b0;
      if (pc_load) begin
        pulses++;
        n_checks++;
        if (cpu_hold !== 1'b0 || prev_hold !== 1'b1) begin
          n_fail++;
          $display("FAIL %s hold_at_pc_load: before=%b during=%b required 1/0", name, prev_hold, cpu_hold);
        end
        n_checks++;
        if (pc_value !== target) begin
          n_fail++;
          $display("FAIL %s pc_value: got %h required %h", name, pc_value, target);
        end
      end
      prev_hold = cpu_hold;
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL %s pc_load_count: got %0d required 1", name, pulses);
    end
    n_checks++;
    if (verify_err !== exp_verr) begin
      n_fail++;
      $display("FAIL %s verify_err: got %b required %b", name, verify_err, exp_verr);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    dn_go = 1'b0; dn_wr = 1'b0; dn_rd = 1'b0; dn_addr = '0; dn_data = '0;
    execute_enable = 1'b0; execute_addr = '0; sdram_ready = 1'b1;
    step(); step();
    n_checks++;
    if ({mem_req, mem_we, cpu_hold, pc_load, verify_err, fault, busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0000000",
               {mem_req, mem_we, cpu_hold, pc_load, verify_err, fault, busy});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, pc_value, wr_sum, rd_sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h pc=%h ws=%h rs=%h required all 0",
               mem_addr, mem_wdata, pc_value, wr_sum, rd_sum);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    ack_en = 1'b1;
    start_session();
    n_checks++;
    if (cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL latency cpu_hold_after_go: got %b required 1", cpu_hold);
    end
    dn_addr = 16'h0100; dn_data = 8'h5A; dn_wr = 1'b1;
    step();
    dn_wr = 1'b0;
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL latency req_early1: got %b required 0", mem_req);
    end
    step();
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL latency req_early2: got %b required 0", mem_req);
    end
    step();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 22'h000100 || mem_wdata !== 8'h5A || mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL latency req_at_3: req=%b addr=%h data=%h we=%b required 1/000100/5a/1",
               mem_req, mem_addr, mem_wdata, mem_we);
    end
    wait_idle("latency");
    n_checks++;
    if (wr_sum !== 16'h005A) begin
      n_fail++;
      $display("FAIL latency wr_sum: got %h required 005a", wr_sum);
    end
  endtask

  task automatic test_session_ok();
    ack_en = 1'b1; corrupt_en = 1'b0;
    start_session();
    n_checks++;
    if (wr_sum !== 16'h0000) begin
      n_fail++;
      $display("FAIL t1 wr_sum_cleared: got %h required 0000", wr_sum);
    end
    strobe_wr(16'h0000, 8'h3E);
    strobe_wr(16'h0001, 8'hC9);
    wait_idle("t1_wr");
    strobe_rd(16'h0000);
    strobe_rd(16'h0001);
    wait_idle("t1_rd");
    n_checks++;
    if (wr_sum !== 16'h0107 || rd_sum !== 16'h0107) begin
      n_fail++;
      $display("FAIL t1 sums: wr=%h rd=%h required 0107/0107", wr_sum, rd_sum);
    end
    do_execute(16'h0000, 1'b0, "t1");
  endtask

  task automatic test_verify_err();
    ack_en = 1'b1; corrupt_en = 1'b1; corrupt_addr = 8'h01;
    start_session();
    strobe_wr(16'h0000, 8'h3E);
    strobe_wr(16'h0001, 8'hC9);
    wait_idle("t2_wr");
    strobe_rd(16'h0000);
    strobe_rd(16'h0001);
    wait_idle("t2_rd");
    corrupt_en = 1'b0;
    n_checks++;
    if (wr_sum !== 16'h0107 || rd_sum !== 16'h0106 || verify_err !== 1'b0) begin
      n_fail++;
      $display("FAIL t2 sums: wr=%h rd=%h verr=%b required 0107/0106/0", wr_sum, rd_sum, verify_err);
    end
    do_execute(16'h1234, 1'b1, "t2");
  endtask

  task automatic test_overflow();
    ack_en = 1'b0;
    start_session();
    n_checks++;
    if (verify_err !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL t3 flags_cleared: verr=%b fault=%b required 0/0", verify_err, fault);
    end
    for (int i = 0; i < 5; i++) strobe_wr(16'h0010 + 16'(i), 8'(i + 1));
    n_checks++;
    if (fault !== 1'b0) begin
      n_fail++;
      $display("FAIL t3 fault_before_full: got %b required 0", fault);
    end
    strobe_wr(16'h0015, 8'h06);
    step();
    n_checks++;
    if (fault !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 22'h000010) begin
      n_fail++;
      $display("FAIL t3 overflow: fault=%b req=%b addr=%h required 1/1/000010", fault, mem_req, mem_addr);
    end
    addr_log.delete();
    ack_en = 1'b1;
    wait_idle("t3");
    n_checks++;
    if (addr_log.size() !== 5) begin
      n_fail++;
      $display("FAIL t3 req_count: got %0d required 5", addr_log.size());
    end
    for (int i = 0; i < addr_log.size() && i < 5; i++) begin
      n_checks++;
      if (addr_log[i] !== 22'h000010 + 22'(i)) begin
        n_fail++;
        $display("FAIL t3 order[%0d]: got %h required %h", i, addr_log[i], 22'h000010 + 22'(i));
      end
    end
    n_checks++;
    if (wr_sum !== 16'h000F) begin
      n_fail++;
      $display("FAIL t3 wr_sum: got %h required 000f", wr_sum);
    end
    dn_go = 1'b0;
    step(); step();
    n_checks++;
    if (cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL t3 hold_after_go_fall: got %b required 0", cpu_hold);
    end
  endtask

  task automatic test_no_session();
    strobe_wr(16'h0077, 8'h88);
    step(); step(); step();
    n_checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || wr_sum !== 16'h000F) begin
      n_fail++;
      $display("FAIL no_session: busy=%b req=%b wr_sum=%h required 0/0/000f", busy, mem_req, wr_sum);
    end
  endtask

  task automatic test_wrap();
    bit seen = 1'b0;
    ack_en = 1'b1;
    start_session();
    dn_addr = 16'h0020; dn_data = 8'hAA; dn_wr = 1'b1;
    step();
    dn_wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    n_checks++;
    if (!seen || mem_addr !== 22'h000020) begin
      n_fail++;
      $display("FAIL t4 base0_addr: req=%b got %h required 000020", seen, mem_addr);
    end
    n_checks++;
    if (w_mem_addr !== 22'h000010) begin
      n_fail++;
      $display("FAIL t4 wrap_addr: got %h required 000010", w_mem_addr);
    end
    wait_idle("t4");
  endtask

  task automatic test_collision();
    ack_en = 1'b1;
    start_session();
    dn_addr = 16'h0040; dn_data = 8'h11; dn_wr = 1'b1; dn_rd = 1'b1;
    step();
    dn_wr = 1'b0; dn_rd = 1'b0;
    wait_idle("collision");
    n_checks++;
    if (fault !== 1'b1 || wr_sum !== 16'h0011 || rd_sum !== 16'h0000) begin
      n_fail++;
      $display("FAIL collision: fault=%b wr=%h rd=%h required 1/0011/0000", fault, wr_sum, rd_sum);
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    ack_en = 1'b1;
    start_session();
    n_checks++;
    if (fault !== 1'b0) begin
      n_fail++;
      $display("FAIL t5 fault_cleared: got %b required 0", fault);
    end
    strobe_wr(16'h0050, 8'h55);
    wait_idle("t5_pre");
    ack_en = 1'b0;
    strobe_wr(16'h0051, 8'h77);
    for (int i = 0; i < 10; i++) begin
      if (mem_req) break;
      step();
    end
    while (mem_req && cnt < 400) begin
      cnt++;
      step();
    end
    n_checks++;
    if (cnt !== 255) begin
      n_fail++;
      $display("FAIL t5 req_cycles: got %0d required 255", cnt);
    end
    n_checks++;
    if (fault !== 1'b1 || wr_sum !== 16'h0055 || rd_sum !== 16'h0000 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL t5 after_timeout: fault=%b wr=%h rd=%h req=%b required 1/0055/0000/0",
               fault, wr_sum, rd_sum, mem_req);
    end
  endtask

  task automatic test_reset_mid_req();
    int pulses = 0;
    ack_en = 1'b0;
    start_session();
    strobe_wr(16'h0030, 8'h99);
    execute_addr = 16'hBEEF; execute_enable = 1'b1;
    step();
    execute_enable = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1 || pc_value !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL t6 precondition: req=%b pc=%h required 1/beef", mem_req, pc_value);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, cpu_hold, pc_load, fault, busy, verify_err} !== 6'b0 ||
        pc_value !== 16'h0000 || wr_sum !== 16'h0000) begin
      n_fail++;
      $display("FAIL t6 async_clear: req=%b hold=%b pcl=%b fault=%b busy=%b pc=%h ws=%h required all 0",
               mem_req, cpu_hold, pc_load, fault, busy, pc_value, wr_sum);
    end
    dn_go = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pc_load) pulses++;
    end
    n_checks++;
    if (pulses !== 0 || cpu_hold !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL t6 after_release: pc_loads=%0d hold=%b req=%b required 0/0/0", pulses, cpu_hold, mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_session_ok();
    test_verify_err();
    test_overflow();
    test_no_session();
    test_wrap();
    test_collision();
    test_timeout();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
